// File: rtl/lin_reg_fit.sv
// lin_reg_fit
//   Per-frame least-squares line fitter. Accumulates x/y moments of every
//   masked pixel in the active region and, after end of frame, solves
//   y = m*x + b with a bit-serial restoring divider during vertical blanking.
//
// Ports
//   clk_65mhz      : pixel clock (single domain)
//   rst_in         : synchronous active-high reset, aborts any solve
//   hcount, vcount : current pixel coordinate
//   mask_cr        : pixel at (hcount, vcount) belongs to the line
//   slope          : signed m, FRAC_BITS fractional bits, saturated, held
//   offset         : signed integer b, saturated, held
//   fit_valid      : one-cycle pulse when a solve completes
//   fit_degenerate : last solve was unusable (held, qualified by fit_valid)
//   busy           : solver running
module lin_reg_fit #(
  parameter int unsigned H_ACTIVE  = 1024,
  parameter int unsigned V_ACTIVE  = 768,
  parameter int unsigned FRAC_BITS = 2,
  parameter int unsigned SLOPE_W   = 9,
  parameter int unsigned OFFSET_W  = 11,
  parameter int unsigned MIN_PIX   = 4
) (
  input  logic                       clk_65mhz,
  input  logic                       rst_in,
  input  logic [10:0]                hcount,
  input  logic [9:0]                 vcount,
  input  logic                       mask_cr,
  output logic signed [SLOPE_W-1:0]  slope,
  output logic signed [OFFSET_W-1:0] offset,
  output logic                       fit_valid,
  output logic                       fit_degenerate,
  output logic                       busy
);

  localparam logic [10:0] H_END  = 11'(H_ACTIVE);
  localparam logic [9:0]  V_END  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_ACTIVE - 1);
  localparam logic [20:0] MIN_N  = 21'(MIN_PIX);

  localparam logic signed [63:0] S_HI = (64'sd1 <<< (SLOPE_W - 1)) - 64'sd1;
  localparam logic signed [63:0] S_LO = -(64'sd1 <<< (SLOPE_W - 1));
  localparam logic signed [63:0] O_HI = (64'sd1 <<< (OFFSET_W - 1)) - 64'sd1;
  localparam logic signed [63:0] O_LO = -(64'sd1 <<< (OFFSET_W - 1));
  localparam logic signed [SLOPE_W-1:0]  S_HI_W = S_HI[SLOPE_W-1:0];
  localparam logic signed [SLOPE_W-1:0]  S_LO_W = S_LO[SLOPE_W-1:0];
  localparam logic signed [OFFSET_W-1:0] O_HI_W = O_HI[OFFSET_W-1:0];
  localparam logic signed [OFFSET_W-1:0] O_LO_W = O_LO[OFFSET_W-1:0];

  typedef enum logic [2:0] {
    ACCUM,
    PREP,
    DIV_M,
    DIV_B,
    DONE
  } state_t;

  state_t state;

  // ---------------------------------------------------------------- moments
  logic        active, hit, eof;
  logic [20:0] xy;
  logic [21:0] xx;

  assign active = (hcount < H_END) && (vcount < V_END);
  assign hit    = active && mask_cr;
  assign eof    = (hcount == H_END) && (vcount == V_LAST);
  assign xy     = {10'b0, hcount} * {11'b0, vcount};
  assign xx     = {11'b0, hcount} * {11'b0, hcount};

  logic [20:0] acc_n;
  logic [30:0] acc_sx, acc_sy;
  logic [40:0] acc_sxy, acc_sxx;

  always_ff @(posedge clk_65mhz) begin
    if (rst_in || eof) begin
      acc_n   <= '0;
      acc_sx  <= '0;
      acc_sy  <= '0;
      acc_sxy <= '0;
      acc_sxx <= '0;
    end else if (hit) begin
      acc_n   <= acc_n + 21'd1;
      acc_sx  <= acc_sx + {20'b0, hcount};
      acc_sy  <= acc_sy + {21'b0, vcount};
      acc_sxy <= acc_sxy + {20'b0, xy};
      acc_sxx <= acc_sxx + {19'b0, xx};
    end
  end

  // ------------------------------------------------------------- snapshot
  logic [20:0] snap_n;
  logic [30:0] snap_sx, snap_sy;
  logic [40:0] snap_sxy, snap_sxx;

  // ------------------------------------------------------------- prep regs
  logic [1:0]         prep_cnt;
  logic [63:0]        p_nsxy, p_sxsy, p_nsxx, p_sxsx;
  logic signed [63:0] num_r, den_r;
  logic               degen_r;

  // -------------------------------------------------------------- divider
  logic [63:0]        dv_q;     // dividend bits shift out, quotient bits shift in
  logic [63:0]        dv_rem;
  logic [63:0]        dv_den;
  logic               dv_neg;
  logic [5:0]         dv_cnt;
  logic signed [63:0] m_q, off_q;

  function automatic logic [63:0] mag(input logic signed [63:0] v);
    return v[63] ? -v : v;
  endfunction

  logic [64:0]        rem_sh;
  logic               rem_ge;
  logic [63:0]        rem_nxt, q_nxt;
  logic signed [63:0] q_sgn_nxt;
  logic signed [63:0] num_sh;
  logic signed [63:0] sx_s, sy_s, b_num;
  logic [63:0]        b_den;

  always_comb begin
    rem_sh = {dv_rem, dv_q[63]};
    rem_ge = (rem_sh >= {1'b0, dv_den});
    if (rem_ge) begin
      rem_nxt = rem_sh[63:0] - dv_den;
      q_nxt   = {dv_q[62:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[63:0];
      q_nxt   = {dv_q[62:0], 1'b0};
    end
    q_sgn_nxt = dv_neg ? -q_nxt : q_nxt;
  end

  // The b-division operands are formed from the final slope quotient in the
  // same cycle as the last slope step, so DIV_B starts with no gap cycle.
  always_comb begin
    num_sh = num_r <<< FRAC_BITS;
    sx_s   = {33'b0, snap_sx};
    sy_s   = {33'b0, snap_sy};
    b_num  = (sy_s <<< FRAC_BITS) - q_sgn_nxt * sx_s;
    b_den  = {43'b0, snap_n} << FRAC_BITS;
  end

  logic signed [SLOPE_W-1:0]  m_sat;
  logic signed [OFFSET_W-1:0] o_sat;

  always_comb begin
    if (m_q > S_HI)      m_sat = S_HI_W;
    else if (m_q < S_LO) m_sat = S_LO_W;
    else                 m_sat = m_q[SLOPE_W-1:0];
    if (off_q > O_HI)      o_sat = O_HI_W;
    else if (off_q < O_LO) o_sat = O_LO_W;
    else                   o_sat = off_q[OFFSET_W-1:0];
  end

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge clk_65mhz) begin
    if (rst_in) begin
      state          <= ACCUM;
      slope          <= '0;
      offset         <= '0;
      fit_valid      <= 1'b0;
      fit_degenerate <= 1'b0;
      busy           <= 1'b0;
      snap_n         <= '0;
      snap_sx        <= '0;
      snap_sy        <= '0;
      snap_sxy       <= '0;
      snap_sxx       <= '0;
      prep_cnt       <= '0;
      p_nsxy         <= '0;
      p_sxsy         <= '0;
      p_nsxx         <= '0;
      p_sxsx         <= '0;
      num_r          <= '0;
      den_r          <= '0;
      degen_r        <= 1'b0;
      dv_q           <= '0;
      dv_rem         <= '0;
      dv_den         <= '0;
      dv_neg         <= 1'b0;
      dv_cnt         <= '0;
      m_q            <= '0;
      off_q          <= '0;
    end else begin
      fit_valid <= 1'b0;
      case (state)
        ACCUM: begin
          if (eof) begin
            snap_n   <= acc_n;
            snap_sx  <= acc_sx;
            snap_sy  <= acc_sy;
            snap_sxy <= acc_sxy;
            snap_sxx <= acc_sxx;
            prep_cnt <= '0;
            busy     <= 1'b1;
            state    <= PREP;
          end
        end

        PREP: begin
          prep_cnt <= prep_cnt + 2'd1;
          case (prep_cnt)
            2'd0: begin
              p_nsxy <= {43'b0, snap_n} * {23'b0, snap_sxy};
              p_sxsy <= {33'b0, snap_sx} * {33'b0, snap_sy};
              p_nsxx <= {43'b0, snap_n} * {23'b0, snap_sxx};
              p_sxsx <= {33'b0, snap_sx} * {33'b0, snap_sx};
            end
            2'd1: begin
              num_r <= p_nsxy - p_sxsy;
              den_r <= p_nsxx - p_sxsx;
            end
            2'd2: begin
              degen_r <= (snap_n < MIN_N) || (den_r == '0);
            end
            default: begin
              dv_q   <= mag(num_sh);
              dv_den <= mag(den_r);
              dv_neg <= num_sh[63] ^ den_r[63];
              dv_rem <= '0;
              dv_cnt <= '0;
              state  <= degen_r ? DONE : DIV_M;
            end
          endcase
        end

        DIV_M: begin
          dv_q   <= q_nxt;
          dv_rem <= rem_nxt;
          dv_cnt <= dv_cnt + 6'd1;
          if (dv_cnt == 6'd63) begin
            m_q    <= q_sgn_nxt;
            dv_q   <= mag(b_num);
            dv_den <= b_den;
            dv_neg <= b_num[63];
            dv_rem <= '0;
            state  <= DIV_B;
          end
        end

        DIV_B: begin
          dv_q   <= q_nxt;
          dv_rem <= rem_nxt;
          dv_cnt <= dv_cnt + 6'd1;
          if (dv_cnt == 6'd63) begin
            off_q <= q_sgn_nxt;
            state <= DONE;
          end
        end

        DONE: begin
          fit_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= ACCUM;
          if (degen_r) begin
            fit_degenerate <= 1'b1;
          end else begin
            slope          <= m_sat;
            offset         <= o_sat;
            fit_degenerate <= 1'b0;
          end
        end

        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/lin_reg_fit.md
# lin_reg_fit

Per-frame least-squares line fitter directly upstream of the line renderer. Accumulates x/y moments of every pixel flagged by `mask_cr` during the active region of a 1024x768 frame. At end of frame it solves y = m·x + b with a sequential divider during vertical blanking. The resulting fixed-point `slope` and integer `offset` feed the renderer's `slope`/`offset` inputs for the next frame.

## Interface
- H_ACTIVE, 1024, active pixels per line
- V_ACTIVE, 768, active lines per frame
- FRAC_BITS, 2, fractional bits of `slope` (Q format)
- SLOPE_W, 9, signed width of `slope`
- OFFSET_W, 11, signed width of `offset`
- MIN_PIX, 4, minimum masked pixels for a valid fit
- clk_65mhz  input  1  pixel clock; one clock domain only
- rst_in  input  1  reset, synchronous, active-high
- hcount  input  11  current pixel x
- vcount  input  10  current pixel y
- mask_cr  input  1  pixel at (hcount, vcount) belongs to the line
- slope  output  SLOPE_W  signed m in Q(FRAC_BITS), held between updates
- offset  output  OFFSET_W  signed b, held between updates
- fit_valid  output  1  one-cycle pulse when a solve completes
- fit_degenerate  output  1  result of last solve was unusable (valid with `fit_valid`, held)
- busy  output  1  solver running

## Operation
- Active pixel: hcount < H_ACTIVE and vcount < V_ACTIVE. Only active pixels with mask_cr=1 accumulate: n+=1, Sx+=x, Sy+=y, Sxy+=x·y, Sxx+=x·x. Widths: n 21b, Sx/Sy 31b, Sxx/Sxy 41b, unsigned.
- EOF event: the cycle with hcount == H_ACTIVE and vcount == V_ACTIVE-1. On EOF, the moments are copied into snapshot registers and the accumulators clear in the same cycle. A masked pixel in that cycle is impossible, because the pixel is not active.
- States: ACCUM (idle solver) -> PREP -> DIV_M -> DIV_B -> DONE -> ACCUM. Accumulation runs in every state.
- PREP (fixed 4 cycles) computes the following as 64-bit signed values:
  - N = n·Sxy − Sx·Sy
  - D = n·Sxx − Sx²
  - If n < MIN_PIX or D == 0, go straight to DONE with degenerate=1.
- DIV_M: m_q = trunc((N·2^FRAC_BITS) / D), rounding toward zero. Uses a restoring signed divider at 1 quotient bit/cycle, 64 cycles.
- DIV_B: uses the unsaturated m_q.
  - b_num = Sy·2^FRAC_BITS − m_q·Sx
  - b_den = n·2^FRAC_BITS
  - offset_raw = trunc(b_num / b_den), 64 cycles.
- DONE (1 cycle):
  - Pulse fit_valid.
  - If not degenerate: slope = sat(m_q, SLOPE_W), offset = sat(offset_raw, OFFSET_W), fit_degenerate=0. sat clamps to [−2^(W−1), 2^(W−1)−1].
  - If degenerate: slope and offset hold previous values, fit_degenerate=1.
- EOF while busy: the in-flight solve completes unchanged. The new snapshot is discarded, but the accumulators still clear.

## Timing
- Reset values: slope=0, offset=0, fit_valid=0, fit_degenerate=0, busy=0. All accumulators, snapshots and the FSM clear to ACCUM.
- rst_in asserted mid-solve aborts the solve. No fit_valid is produced, and outputs take their reset values on the next edge.
- busy rises the cycle after EOF and falls the cycle after DONE.
- Latency, normal path: EOF edge to fit_valid is 1 (capture) + 4 + 64 + 64 + 1 = exactly 134 cycles.
- Latency, degenerate path: exactly 6 cycles.
- slope and offset change only in the DONE cycle, coincident with fit_valid=1. They are stable for the rest of the frame, so the downstream renderer can sample them at any time.
- Throughput: one solve per frame. The 134-cycle solve is far shorter than the vertical blanking interval.

## Test plan
- Masked pixels (x, 2x+1) for x=0..9, then EOF -> fit_valid 134 cycles later, slope=8 (2.0), offset=1, fit_degenerate=0.
- Masked (x, 7−x) for x=0..7 -> slope=−4 (−1.0), offset=7. Checks the negative numerator and the truncation sign.
- Masked (x, x/4+4) for x=0,4,…,36 -> slope=1 (0.25), offset=4. Checks the fractional path.
- Vertical set (50, y) for y=0..99 -> D=0: fit_degenerate=1 after 6 cycles, slope/offset hold prior values. Then 3 pixels only (n < MIN_PIX) -> degenerate again.
- Masked (x, 100x) for x=0..3 -> slope saturates to 255, offset=0 (computed from unsaturated m_q=400).
- Reset pulse 40 cycles after EOF during DIV_M -> no fit_valid; all outputs 0 next cycle. The following frame with the y=2x+1 pattern -> slope=8, offset=1.
